// File: rtl/rotate_frame_ctrl.sv
// Frame sequencer for the image-rotation path: raster LOAD into a single-port SRAM,
// then rotated READ with valid/ready backpressure. Define ROT_ANY_EN to add run-time rot_sel.
module rotate_frame_ctrl #(
   parameter int DIM_BITS = 8,
   parameter int PIX_W    = 24,
   parameter int MEM_W    = 32,
   parameter int ADDR_W   = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
`ifdef ROT_ANY_EN
   input  logic [1:0]        rot_sel,
`endif
   input  logic              in_valid,
   input  logic [PIX_W-1:0]  in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [PIX_W-1:0]  out_data,
   input  logic              out_ready,
   output logic              out_eol,
   output logic              out_last,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [MEM_W-1:0]  mem_wdata,
   input  logic [MEM_W-1:0]  mem_rdata,
   output logic              busy,
   output logic              frame_done
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_READ, ST_DONE} state_t;
   typedef enum logic [1:0] {ROT_0, ROT_90, ROT_180, ROT_270} rot_t;

   localparam logic [DIM_BITS-1:0] IDX_MAX = '1;
   localparam logic [DIM_BITS-1:0] IDX_ONE = 1;

   state_t state_q, state_d;
   rot_t   rot_cur;

   logic [DIM_BITS-1:0] wr_row, wr_col;
   logic [DIM_BITS-1:0] rd_row, rd_col;
   logic [DIM_BITS-1:0] src_row, src_col;
   logic                rd_fin;

   logic                inflight_q, inflight_eol_q, inflight_last_q;
   logic [PIX_W-1:0]    fifo_data [2];
   logic                fifo_eol  [2];
   logic                fifo_last [2];
   logic                head_q, tail_q;
   logic [1:0]          cnt_q;
   logic [2:0]          occ;

   logic flush, wr_last, rd_last, do_write, do_read, pop, head_last;
   logic unused_rdata;

   assign unused_rdata = &{1'b0, mem_rdata};

   assign flush     = abort || (state_q == ST_IDLE);
   assign wr_last   = (wr_row == IDX_MAX) && (wr_col == IDX_MAX);
   assign rd_last   = (rd_row == IDX_MAX) && (rd_col == IDX_MAX);
   assign out_valid = (cnt_q != 2'd0);
   assign pop       = out_valid && out_ready;
   assign head_last = fifo_last[head_q];

   // Occupancy after this cycle if nothing new is issued; one slot must stay free per issue.
   assign occ      = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign do_write = (state_q == ST_LOAD) && in_valid && !abort;
   assign do_read  = (state_q == ST_READ) && !rd_fin && !abort && (occ < 3'd2);

   assign in_ready   = (state_q == ST_LOAD) && !abort;
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = (state_q == ST_DONE);
   assign mem_en     = do_write || do_read;
   assign mem_we     = do_write;
   assign out_data   = out_valid ? fifo_data[head_q] : '0;
   assign out_eol    = out_valid && fifo_eol[head_q];
   assign out_last   = out_valid && head_last;

`ifdef ROT_ANY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rot_cur <= ROT_0;
      end else if ((state_q == ST_IDLE) && start && !abort) begin
         rot_cur <= rot_t'(rot_sel);
      end
   end
`else
   assign rot_cur = ROT_90;
`endif

   // NOTE: every state register uses non-blocking assignment so all flops update together
   // at the edge, independent of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: defaults are assigned before the case so no path leaves state_d unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start)                 state_d = ST_LOAD;
         ST_LOAD: if (do_write && wr_last)   state_d = ST_READ;
         ST_READ: if (pop && head_last)      state_d = ST_DONE;
         ST_DONE:                            state_d = ST_IDLE;
         default:                            state_d = ST_IDLE;
      endcase
      if (abort) state_d = ST_IDLE;
   end

   // N-1-x modulo N is simply the bitwise complement of x.
   always_comb begin
      src_row = rd_row;
      src_col = rd_col;
      unique case (rot_cur)
         ROT_0:   begin src_row = rd_row;  src_col = rd_col;  end
         ROT_90:  begin src_row = ~rd_col; src_col = rd_row;  end
         ROT_180: begin src_row = ~rd_row; src_col = ~rd_col; end
         ROT_270: begin src_row = rd_col;  src_col = ~rd_row; end
         default: begin src_row = rd_row;  src_col = rd_col;  end
      endcase
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      if (do_write) begin
         mem_addr[2*DIM_BITS-1:0] = {wr_row, wr_col};
         mem_wdata[PIX_W-1:0]     = in_data;
      end else if (do_read) begin
         mem_addr[2*DIM_BITS-1:0] = {src_row, src_col};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_row <= '0;
         wr_col <= '0;
      end else if (flush) begin
         wr_row <= '0;
         wr_col <= '0;
      end else if (do_write) begin
         wr_col <= wr_col + IDX_ONE;
         if (wr_col == IDX_MAX) wr_row <= wr_row + IDX_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_row          <= '0;
         rd_col          <= '0;
         rd_fin          <= 1'b0;
         inflight_q      <= 1'b0;
         inflight_eol_q  <= 1'b0;
         inflight_last_q <= 1'b0;
      end else if (flush) begin
         rd_row          <= '0;
         rd_col          <= '0;
         rd_fin          <= 1'b0;
         inflight_q      <= 1'b0;
         inflight_eol_q  <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         inflight_q      <= do_read;
         inflight_eol_q  <= (rd_col == IDX_MAX);
         inflight_last_q <= rd_last;
         if (do_read) begin
            rd_col <= rd_col + IDX_ONE;
            if (rd_col == IDX_MAX) rd_row <= rd_row + IDX_ONE;
            if (rd_last) rd_fin <= 1'b1;
         end
      end
   end

   // NOTE: the two payload slots are reset only so outputs come up clean; a flush just
   // drops the count, since out_data/out_eol/out_last are masked by out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            fifo_data[i] <= '0;
            fifo_eol[i]  <= 1'b0;
            fifo_last[i] <= 1'b0;
         end
         head_q <= 1'b0;
         tail_q <= 1'b0;
         cnt_q  <= 2'd0;
      end else if (flush) begin
         head_q <= 1'b0;
         tail_q <= 1'b0;
         cnt_q  <= 2'd0;
      end else begin
         if (inflight_q) begin
            fifo_data[tail_q] <= mem_rdata[PIX_W-1:0];
            fifo_eol[tail_q]  <= inflight_eol_q;
            fifo_last[tail_q] <= inflight_last_q;
            tail_q            <= ~tail_q;
         end
         if (pop) head_q <= ~head_q;
         cnt_q <= occ[1:0];
      end
   end

endmodule

// File: tb/tb_rotate_frame_ctrl.sv
// Directed bench for rotate_frame_ctrl at N=4 with a 1-cycle-latency SRAM model.
// Frame-level vectors from a table, plus hand sequences for reset-in-READ and abort-in-LOAD.
module tb_rotate_frame_ctrl;
   localparam int DIM_BITS = 2;
   localparam int PIX_W    = 24;
   localparam int MEM_W    = 32;
   localparam int ADDR_W   = 20;
   localparam int NPIX     = 16;

   logic              clk = 1'b0;
   logic              rst_n, start, abort, in_valid, out_ready;
   logic [PIX_W-1:0]  in_data;
   logic              in_ready, out_valid, out_eol, out_last;
   logic [PIX_W-1:0]  out_data;
   logic              mem_en, mem_we, busy, frame_done;
   logic [ADDR_W-1:0] mem_addr;
   logic [MEM_W-1:0]  mem_wdata, mem_rdata;
`ifdef ROT_ANY_EN
   logic [1:0]        rot_sel;
`endif

   rotate_frame_ctrl #(
      .DIM_BITS(DIM_BITS), .PIX_W(PIX_W), .MEM_W(MEM_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef ROT_ANY_EN
      .rot_sel(rot_sel),
`endif
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .out_eol(out_eol), .out_last(out_last),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   logic [MEM_W-1:0] sram [NPIX];
   int rd_issued = 0;
   int done_cnt  = 0;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) sram[mem_addr[3:0]] <= mem_wdata;
         else        mem_rdata <= sram[mem_addr[3:0]];
      end
      if (mem_en && !mem_we) rd_issued <= rd_issued + 1;
      if (frame_done)        done_cnt  <= done_cnt + 1;
   end

   int n_checks = 0;
   int n_fail   = 0;
   logic [1:0] cur_rot = 2'd1;

   // Hand-computed output orders for pixels 0..15 loaded row-major.
   int unsigned exp90  [NPIX] = '{12, 8, 4, 0, 13, 9, 5, 1, 14, 10, 6, 2, 15, 11, 7, 3};
   int unsigned exp180 [NPIX] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};

   typedef struct {
      string      name;
      logic [1:0] rot;
      bit         gaps;
      bit         toggle;
      logic [7:0] base;
   } frame_vec_t;

   frame_vec_t vecs [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"},   in_ready,   0);
      check({tag, "_out_valid"},  out_valid,  0);
      check({tag, "_out_data"},   out_data,   0);
      check({tag, "_out_eol"},    out_eol,    0);
      check({tag, "_out_last"},   out_last,   0);
      check({tag, "_mem_en"},     mem_en,     0);
      check({tag, "_mem_we"},     mem_we,     0);
      check({tag, "_mem_addr"},   mem_addr,   0);
      check({tag, "_mem_wdata"},  mem_wdata,  0);
      check({tag, "_busy"},       busy,       0);
      check({tag, "_frame_done"}, frame_done, 0);
   endtask

   task automatic do_start(input logic [1:0] rot);
      cur_rot = rot;
`ifdef ROT_ANY_EN
      rot_sel = rot;
`endif
      start = 1'b1;
      tick();
      start = 1'b0;
`ifdef ROT_ANY_EN
      rot_sel = ~rot;
`endif
      check("busy_after_start", busy, 1);
   endtask

   task automatic load_frame(input logic [7:0] base, input bit gaps, input int npix);
      int p   = 0;
      int cyc = 0;
      bit v;
      while (p < npix && cyc < 200) begin
         v        = !(gaps && (cyc % 3 == 1));
         in_valid = v;
         in_data  = PIX_W'(base + p);
         #1;
         check("load_in_ready", in_ready, 1);
         check("load_mem_en", mem_en, v);
         if (v) begin
            check("load_mem_we", mem_we, 1);
            check("load_addr", mem_addr, p);
            check("load_wdata", mem_wdata, base + p);
         end
         @(posedge clk);
         #1;
         if (v) p++;
         cyc++;
      end
      in_valid = 1'b0;
      in_data  = '0;
      check("load_count", p, npix);
   endtask

   task automatic read_frame(input logic [7:0] base, input bit toggle);
      int k    = 0;
      int cyc  = 0;
      bit held = 1'b0;
      logic [PIX_W-1:0] hd = '0;
      logic he = 1'b0;
      logic hl = 1'b0;
      int unsigned e;
      out_ready = 1'b1;
      check("lat_c0_valid", out_valid, 0);
      tick();
      check("lat_c1_valid", out_valid, 0);
      tick();
      check("lat_c2_valid", out_valid, 1);
      while (k < NPIX && cyc < 400) begin
         out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
         if (held) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, hd);
            check("hold_eol", out_eol, he);
            check("hold_last", out_last, hl);
         end
         if (out_valid) begin
            e = base + ((cur_rot == 2'd2) ? exp180[k] : exp90[k]);
            check("out_data", out_data, e);
            check("out_eol", out_eol, (k % 4) == 3);
            check("out_last", out_last, k == NPIX - 1);
            held = !out_ready;
            hd   = out_data;
            he   = out_eol;
            hl   = out_last;
            if (out_ready) k++;
         end else begin
            held = 1'b0;
         end
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      check("read_count", k, NPIX);
      if (!toggle) check("read_throughput_cycles", cyc, NPIX);
   endtask

   task automatic run_frame(input frame_vec_t v);
      int r0, d0;
      d0 = done_cnt;
      do_start(v.rot);
      load_frame(v.base, v.gaps, NPIX);
      check({v.name, "_in_ready_read"}, in_ready, 0);
      check({v.name, "_busy_read"}, busy, 1);
      r0 = rd_issued;
      read_frame(v.base, v.toggle);
      check({v.name, "_frame_done"}, frame_done, 1);
      check({v.name, "_busy_done"}, busy, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check({v.name, "_frame_done_clr"}, frame_done, 0);
      check({v.name, "_idle_after_done"}, busy, 0);
      check({v.name, "_reads_issued"}, rd_issued - r0, NPIX);
      check({v.name, "_done_pulses"}, done_cnt - d0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      rst_n     = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
`ifdef ROT_ANY_EN
      rot_sel   = 2'd0;
`endif
      vecs.push_back('{"rot90_full",  2'd1, 1'b0, 1'b0, 8'h00});
      vecs.push_back('{"rot90_stall", 2'd1, 1'b0, 1'b1, 8'h00});
      vecs.push_back('{"rot90_gaps",  2'd1, 1'b1, 1'b1, 8'h40});
`ifdef ROT_ANY_EN
      vecs.push_back('{"rot180",      2'd2, 1'b0, 1'b0, 8'h00});
`endif

      #1;
      check_all_zero("reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_all_zero("post_reset");

      for (int i = 0; i < vecs.size(); i++) run_frame(vecs[i]);

      // Reset asserted in READ while out_valid is high.
      do_start(2'd1);
      load_frame(8'h00, 1'b0, NPIX);
      out_ready = 1'b0;
      tick();
      tick();
      check("pre_reset_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("reset_in_read");
      tick();
      rst_n = 1'b1;
      tick();
      run_frame('{"after_reset", 2'd1, 1'b0, 1'b0, 8'h10});

      // Abort part-way through LOAD: no frame_done for that frame.
      d0 = done_cnt;
      do_start(2'd1);
      load_frame(8'h80, 1'b0, 7);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_in_ready", in_ready, 0);
      check("abort_no_done", done_cnt - d0, 0);
      tick();
      run_frame('{"after_abort", 2'd1, 1'b0, 1'b1, 8'h20});
      check("abort_total_done", done_cnt - d0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
